countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  mm:ss BCD countdown timer; the down-counting counterpart of the real-time clock. Same push-button/7-seg front panel.
//  Operator loads minutes/seconds with buttons, starts/pauses, and is flagged at 00:00.
//  Drives four 7-seg digits through the existing deco_bcd_7seg decoder.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per 1 s decrement (bench uses 4)
//  TIC_W          26          width of tick counter, >= clog2(TICKS_PER_SEC)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset, asynchronous, active-low
//  start_stop  in   1  push button, raw level: start / pause / resume
//  inc_min     in   1  push button, raw level: minutes +1
//  inc_sec     in   1  push button, raw level: seconds +1
//  clear       in   1  push button, raw level: abort to 00:00 / IDLE
//  dMin,uMin   out  7  tens/units of minutes, 7-seg (deco_bcd_7seg encoding)
//  dSec,uSec   out  7  tens/units of seconds, 7-seg
//  running     out  1  1 while in RUN
//  expired     out  1  1 while in DONE
// BEHAVIOUR
//  Reset: state IDLE, time 00:00, tick cnt 0, running=0, expired=0, all digits show "0".
//  Buttons: 2-flop sync + rising-edge detect. One-cycle pulse 3 clk after raw rise. Held level = one event.
//  Time regs: 4 BCD digits. Minutes 00..59. Seconds 00..59. No binary intermediate.
//  FSM IDLE/RUN/PAUSE/DONE. Priority per cycle: clear > start_stop > inc_*.
//   IDLE : inc_min -> mm+1, 59->00. inc_sec -> ss+1, 59->00, no carry to mm.
//          Both inc the same cycle -> both apply.
//          start_stop with time!=00:00 -> RUN, tick cnt:=0. With 00:00 -> stays IDLE.
//   RUN  : tick cnt counts 0..TICKS_PER_SEC-1. At wrap, time decrements by 1 s.
//          ss 00 borrows from mm (ss:=59). Decrement yielding 00:00 -> DONE on the same edge.
//          start_stop -> PAUSE. If tick wrap and start_stop coincide: decrement applies, then PAUSE.
//          inc_* ignored.
//   PAUSE: tick cnt frozen (not cleared). inc_* ignored. start_stop -> RUN, resumes partial second.
//   DONE : time held 00:00, expired=1. start_stop and inc_* ignored. Only clear or rst exits.
//  clear (any state): next cycle IDLE, time 00:00, tick cnt 0, running=0, expired=0.
//  running/expired are registered. They change on the same edge as the state.
//  Digit outputs are combinational decode of the time regs.
//  rst mid-count: immediate async return to reset values. No pending button event survives.
// CONFIGURATION
//  CDT_BLINK_EN defined:
//   In DONE, all four digit outputs alternate "0" / blank (7'b0000000 from the decoder output mux).
//   Each phase lasts TICKS_PER_SEC cycles, starting with "0". The tick counter free-runs in DONE.
//   expired stays steady 1.
//  CDT_BLINK_EN undefined: DONE shows steady 00:00. Tick counter held at 0 in DONE.
// STRUCTURE
//  cdt_pkg:
//   typedef enum logic [1:0] {IDLE,RUN,PAUSE,DONE} cdt_state_t
//   typedef logic [3:0] bcd_t
//   localparams MAX_UNITS=9, MAX_TENS=5
//  Sub-module button_edge: sync + rising-edge pulse, 4 instances.
//  Reuse deco_bcd_7seg for the four digits.
// TESTING (TICKS_PER_SEC=4)
//  1. rst low mid-RUN at 01:30 -> all outputs return to reset values immediately. Digits show 00:00.
//  2. inc_min x2, inc_sec x5, start_stop -> 02:05 and running=1.
//     After 4 clk: 02:04. After 5 s: 01:59, mm/ss borrow checked.
//  3. Load 00:02, start -> 00:01 after 4 clk, 00:00 after 8 clk.
//     expired=1 and running=0 on the same edge; start_stop/inc_sec ignored.
//  4. Load 00:03, start, pause after 6 clk (00:02, tick=2), wait 20 clk (no change), resume.
//     -> 00:01 exactly 2 clk later.
//  5. Load 59:59, inc_sec -> 59:00. inc_min -> 00:00. start_stop at 00:00 -> stays IDLE.
//  6. Simultaneous clear+start_stop in IDLE at 00:10 -> IDLE 00:00.
//     With CDT_BLINK_EN in DONE: digits toggle 0/blank every 4 clk.

Source files
------------

// File: rtl/cdt_pkg.sv
// Shared types and BCD helpers for the mm:ss countdown timer.
package cdt_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cdt_state_t;
  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_UNITS = 4'd9;
  localparam bcd_t MAX_TENS  = 4'd5;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  // 00..59 with wrap 59 -> 00, digit by digit
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == MAX_UNITS) begin
      r.units = '0;
      r.tens  = (v.tens == MAX_TENS) ? bcd_t'(0) : v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  // 00..59 with wrap 00 -> 59 (the borrow case for seconds)
  function automatic bcd2_t bcd2_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == '0) begin
      r.units = MAX_UNITS;
      r.tens  = (v.tens == '0) ? MAX_TENS : v.tens - 4'd1;
    end else begin
      r.units = v.units - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_button_edge.sv
// Push-button front end: 2-flop synchroniser plus registered rising-edge pulse.
module button_edge (
  input  logic clk,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic       pulse_q;

  // sync_q[1:0] is the synchroniser, sync_q[2] the previous synchronised level
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], btn_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/deco_bcd_7seg.sv
// BCD to 7-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
module deco_bcd_7seg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (bcd_i)
      4'd0: seg_o = 7'b0111111;
      4'd1: seg_o = 7'b0000110;
      4'd2: seg_o = 7'b1011011;
      4'd3: seg_o = 7'b1001111;
      4'd4: seg_o = 7'b1100110;
      4'd5: seg_o = 7'b1101101;
      4'd6: seg_o = 7'b1111101;
      4'd7: seg_o = 7'b0000111;
      4'd8: seg_o = 7'b1111111;
      4'd9: seg_o = 7'b1101111;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer with push-button load, start/pause and 00:00 flag.
// Optional CDT_BLINK_EN: digits alternate "0"/blank while expired.
module countdown_timer
  import cdt_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TIC_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       clear,
  output logic [6:0] dMin,
  output logic [6:0] uMin,
  output logic [6:0] dSec,
  output logic [6:0] uSec,
  output logic       running,
  output logic       expired
);

  logic ss_p, min_p, sec_p, clr_p;

  button_edge u_btn_ss  (.clk(clk), .rst_n_i(rst), .btn_i(start_stop), .pulse_o(ss_p));
  button_edge u_btn_min (.clk(clk), .rst_n_i(rst), .btn_i(inc_min),    .pulse_o(min_p));
  button_edge u_btn_sec (.clk(clk), .rst_n_i(rst), .btn_i(inc_sec),    .pulse_o(sec_p));
  button_edge u_btn_clr (.clk(clk), .rst_n_i(rst), .btn_i(clear),      .pulse_o(clr_p));

  cdt_state_t       state_q, state_d;
  bcd2_t            min_q, min_d, sec_q, sec_d;
  logic [TIC_W-1:0] tick_q, tick_d, tick_inc;
  logic             running_q, running_d, expired_q, expired_d;
  logic             blank_q, blank_d;
  logic             tick_wrap, time_zero, dec_zero;
  bcd2_t            min_dec, sec_dec;

  assign tick_wrap = (tick_q == TIC_W'(TICKS_PER_SEC - 1));
  assign tick_inc  = tick_wrap ? '0 : tick_q + 1'b1;
  assign time_zero = (min_q == '0) && (sec_q == '0);
  assign sec_dec   = bcd2_dec(sec_q);
  assign min_dec   = (sec_q == '0) ? bcd2_dec(min_q) : min_q;
  assign dec_zero  = (min_dec == '0) && (sec_dec == '0);

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tick_d    = tick_q;
    running_d = running_q;
    expired_d = expired_q;
    blank_d   = blank_q;
    if (clr_p) begin
      state_d   = IDLE;
      min_d     = '0;
      sec_d     = '0;
      tick_d    = '0;
      running_d = 1'b0;
      expired_d = 1'b0;
      blank_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tick_d = '0;
          if (ss_p) begin
            if (!time_zero) begin
              state_d   = RUN;
              running_d = 1'b1;
            end
          end else begin
            if (min_p) min_d = bcd2_inc(min_q);
            if (sec_p) sec_d = bcd2_inc(sec_q);
          end
        end
        RUN: begin
          tick_d = tick_inc;
          if (ss_p) begin
            state_d   = PAUSE;
            running_d = 1'b0;
          end
          // A wrap that reaches 00:00 wins over a coincident pause
          if (tick_wrap) begin
            min_d = min_dec;
            sec_d = sec_dec;
            if (dec_zero) begin
              state_d   = DONE;
              running_d = 1'b0;
              expired_d = 1'b1;
              tick_d    = '0;
              blank_d   = 1'b0;
            end
          end
        end
        PAUSE: begin
          if (ss_p) begin
            state_d   = RUN;
            running_d = 1'b1;
          end
        end
        DONE: begin
`ifdef CDT_BLINK_EN
          tick_d = tick_inc;
          if (tick_wrap) blank_d = ~blank_q;
`else
          tick_d = '0;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      tick_q    <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      expired_q <= expired_d;
      blank_q   <= blank_d;
    end
  end

  logic [6:0] seg_dm, seg_um, seg_ds, seg_us;

  deco_bcd_7seg u_dec_dm (.bcd_i(min_q.tens),  .seg_o(seg_dm));
  deco_bcd_7seg u_dec_um (.bcd_i(min_q.units), .seg_o(seg_um));
  deco_bcd_7seg u_dec_ds (.bcd_i(sec_q.tens),  .seg_o(seg_ds));
  deco_bcd_7seg u_dec_us (.bcd_i(sec_q.units), .seg_o(seg_us));

`ifdef CDT_BLINK_EN
  assign dMin = blank_q ? 7'b0000000 : seg_dm;
  assign uMin = blank_q ? 7'b0000000 : seg_um;
  assign dSec = blank_q ? 7'b0000000 : seg_ds;
  assign uSec = blank_q ? 7'b0000000 : seg_us;
`else
  assign dMin = seg_dm;
  assign uMin = seg_um;
  assign dSec = seg_ds;
  assign uSec = seg_us;
`endif

  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with TICKS_PER_SEC=4.
module tb_countdown_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0, inc_min = 1'b0, inc_sec = 1'b0, clear = 1'b0;
  logic [6:0] dMin, uMin, dSec, uSec;
  logic       running, expired;

  countdown_timer #(.TICKS_PER_SEC(TPS), .TIC_W(4)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .inc_min(inc_min),
    .inc_sec(inc_sec), .clear(clear), .dMin(dMin), .uMin(uMin),
    .dSec(dSec), .uSec(uSec), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_min; int n_sec; bit start; int wait_cyc;
    int e_mm;  int e_ss;  bit e_run; bit e_exp;
  } vec_t;

  typedef struct packed {
    logic [6:0] dm; logic [6:0] um; logic [6:0] ds; logic [6:0] us;
    logic run; logic ex;
  } obs_t;

  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic obs_t mk(input int mm, input int ss, input bit r, input bit e);
    obs_t o;
    o.dm = seg(mm / 10); o.um = seg(mm % 10);
    o.ds = seg(ss / 10); o.us = seg(ss % 10);
    o.run = r; o.ex = e;
    return o;
  endfunction

  function automatic obs_t mk_blank(input bit r, input bit e);
    obs_t o;
    o = '0;
    o.run = r; o.ex = e;
    return o;
  endfunction

  task automatic expect_now(input obs_t e);
    sb_q.push_back(e);
  endtask

  task automatic check(input string name);
    obs_t a, e;
    a = {dMin, uMin, dSec, uSec, running, expired};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued, got %h", name, a);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", name, a, e);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the edge where the FSM acts.
  task automatic press(input int which);
    case (which)
      0: start_stop = 1'b1;
      1: inc_min = 1'b1;
      2: inc_sec = 1'b1;
      3: clear = 1'b1;
      default: begin clear = 1'b1; start_stop = 1'b1; end
    endcase
    @(negedge clk); @(negedge clk);
    start_stop = 1'b0; inc_min = 1'b0; inc_sec = 1'b0; clear = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic load(input int mm, input int ss);
    press(3);
    repeat (mm) press(1);
    repeat (ss) press(2);
  endtask

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{0, 0,  1'b0, 0,  0, 0,  1'b0, 1'b0};
    vecs[1]  = '{2, 5,  1'b1, 0,  2, 5,  1'b1, 1'b0};
    vecs[2]  = '{2, 5,  1'b1, 4,  2, 4,  1'b1, 1'b0};
    vecs[3]  = '{2, 5,  1'b1, 24, 1, 59, 1'b1, 1'b0};
    vecs[4]  = '{0, 2,  1'b1, 4,  0, 1,  1'b1, 1'b0};
    vecs[5]  = '{0, 2,  1'b1, 8,  0, 0,  1'b0, 1'b1};
    vecs[6]  = '{0, 2,  1'b1, 18, 0, 0,  1'b0, 1'b1};
    vecs[7]  = '{0, 0,  1'b1, 4,  0, 0,  1'b0, 1'b0};
    vecs[8]  = '{1, 1,  1'b0, 10, 1, 1,  1'b0, 1'b0};
    vecs[9]  = '{0, 61, 1'b0, 0,  0, 1,  1'b0, 1'b0};
    vecs[10] = '{60, 0, 1'b0, 0,  0, 0,  1'b0, 1'b0};
    vecs[11] = '{10, 10, 1'b0, 0, 10, 10, 1'b0, 1'b0};
    vecs[12] = '{0, 10, 1'b1, 3,  0, 10, 1'b1, 1'b0};

    @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("reset_state");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      load(vecs[i].n_min, vecs[i].n_sec);
      if (vecs[i].start) press(0);
      repeat (vecs[i].wait_cyc) @(negedge clk);
      expect_now(mk(vecs[i].e_mm, vecs[i].e_ss, vecs[i].e_run, vecs[i].e_exp));
      check($sformatf("vec%0d", i));
    end

    // async reset mid-RUN at 01:30
    load(1, 30);
    press(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("rst_mid_run");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("rst_release_idle");

    // inc_sec in flight when reset hits must not survive
    inc_sec = 1'b1;
    @(negedge clk);
    inc_sec = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("rst_drops_pending");

    // DONE ignores start_stop and inc_sec
    load(0, 2);
    press(0);
    repeat (8) @(negedge clk);
    press(0);
    press(2);
    press(1);
    expect_now(mk(0, 0, 1'b0, 1'b1));
    check("done_ignores_buttons");

    // pause at tick=2, hold, resume finishes the partial second
    load(0, 3);
    press(0);
    repeat (2) @(negedge clk);
    press(0);
    expect_now(mk(0, 2, 1'b0, 1'b0));
    check("pause_entry");
    repeat (20) @(negedge clk);
    press(2);
    expect_now(mk(0, 2, 1'b0, 1'b0));
    check("pause_frozen");
    press(0);
    expect_now(mk(0, 2, 1'b1, 1'b0));
    check("resume");
    @(negedge clk);
    expect_now(mk(0, 2, 1'b1, 1'b0));
    check("resume_plus1");
    @(negedge clk);
    expect_now(mk(0, 1, 1'b1, 1'b0));
    check("resume_plus2");

    // tick wrap and pause on the same edge: decrement, then PAUSE
    load(0, 3);
    press(0);
    press(0);
    expect_now(mk(0, 2, 1'b0, 1'b0));
    check("wrap_and_pause");
    repeat (8) @(negedge clk);
    expect_now(mk(0, 2, 1'b0, 1'b0));
    check("wrap_and_pause_hold");

    // 59:59 wrap cases, start at 00:00 stays IDLE
    load(59, 59);
    expect_now(mk(59, 59, 1'b0, 1'b0));
    check("load_5959");
    press(2);
    expect_now(mk(59, 0, 1'b0, 1'b0));
    check("sec_wrap_no_carry");
    press(1);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("min_wrap");
    press(0);
    repeat (8) @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("start_at_zero");

    // both increments in one cycle
    press(3);
    inc_min = 1'b1; inc_sec = 1'b1;
    @(negedge clk); @(negedge clk);
    inc_min = 1'b0; inc_sec = 1'b0;
    @(negedge clk); @(negedge clk);
    expect_now(mk(1, 1, 1'b0, 1'b0));
    check("both_inc");

    // clear beats start_stop
    load(0, 10);
    press(4);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("clear_over_start");
    repeat (8) @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("clear_over_start_hold");

    // clear out of RUN
    load(3, 0);
    press(0);
    repeat (5) @(negedge clk);
    press(3);
    expect_now(mk(0, 0, 1'b0, 1'b0));
    check("clear_from_run");

`ifdef CDT_BLINK_EN
    load(0, 1);
    press(0);
    repeat (4) @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b1));
    check("blink_enter");
    repeat (3) @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b1));
    check("blink_phase0_end");
    @(negedge clk);
    expect_now(mk_blank(1'b0, 1'b1));
    check("blink_blank");
    repeat (3) @(negedge clk);
    expect_now(mk_blank(1'b0, 1'b1));
    check("blink_blank_end");
    @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b1));
    check("blink_back");
`else
    load(0, 1);
    press(0);
    repeat (12) @(negedge clk);
    expect_now(mk(0, 0, 1'b0, 1'b1));
    check("done_steady");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
